// File: rtl/paging_unit_if.sv
// paging_unit_if: core-side bus of the paging unit (special-register port, data/program translation channels, status).
// Ports (master = core, slave = paging_unit):
//   sr_ie/sr_sel/sr_in -> special-register write, sr_out <- combinational read of sr_sel
//   sup, pc_commit, irq_take -> core mode and control-flow events
//   d_req/d_we/d_vaddr -> data access, d_paddr/d_fault <- translated address and fault
//   p_req/p_vaddr -> fetch, p_paddr/p_fault <- translated address and fault
//   busy, fault_irq <- flush in progress, latched fault level
interface paging_unit_if #(
    parameter int VADDR_W = 16,
    parameter int PAGE_BITS = 4,
    parameter int PPN_W = 8
);
    localparam int PADDR_W = PPN_W + VADDR_W - PAGE_BITS;
    logic sr_ie;
    logic [15:0] sr_sel;
    logic [15:0] sr_in;
    logic [15:0] sr_out;
    logic sup;
    logic pc_commit;
    logic irq_take;
    logic d_req;
    logic d_we;
    logic [VADDR_W-1:0] d_vaddr;
    logic [PADDR_W-1:0] d_paddr;
    logic d_fault;
    logic p_req;
    logic [VADDR_W-1:0] p_vaddr;
    logic [PADDR_W-1:0] p_paddr;
    logic p_fault;
    logic busy;
    logic fault_irq;
    modport master (
        output sr_ie, sr_sel, sr_in, sup, pc_commit, irq_take, d_req, d_we, d_vaddr, p_req, p_vaddr,
        input sr_out, d_paddr, d_fault, p_paddr, p_fault, busy, fault_irq
    );
    modport slave (
        input sr_ie, sr_sel, sr_in, sup, pc_commit, irq_take, d_req, d_we, d_vaddr, p_req, p_vaddr,
        output sr_out, d_paddr, d_fault, p_paddr, p_fault, busy, fault_irq
    );
endinterface

// File: rtl/paging_unit.sv
// paging_unit: translates data and program addresses through two page tables, latches faults, flushes tables in hardware.
// Ports:
//   clk - clock
//   rst - synchronous active-low reset (starts a table flush)
//   bus - paging_unit_if.slave: special-register access, data/program channels, busy and fault_irq
module paging_unit #(
    parameter int VADDR_W = 16,
    parameter int PAGE_BITS = 4,
    parameter int PPN_W = 8
) (
    input logic clk,
    input logic rst,
    paging_unit_if.slave bus
);
    localparam int ENTRIES = 2 ** PAGE_BITS;
    localparam int OFF_W = VADDR_W - PAGE_BITS;
    localparam int PADDR_W = PPN_W + OFF_W;
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t state, state_d;
    logic [PAGE_BITS-1:0] cnt, cnt_d, idx, d_pg, p_pg;
    logic [ENTRIES-1:0] d_v, d_wp, p_v, p_wp;
    logic [PPN_W-1:0] d_ppn [ENTRIES];
    logic [PPN_W-1:0] p_ppn [ENTRIES];
    logic dpg, ppg, ppg_buf, fv, fw, fp, ovf;
    logic [1:0] sav;
    logic [VADDR_W-1:0] faddr;
    logic busy, wr, wr_ctrl, wr_fstat, sel_d, sel_p, unused;

    assign busy = state == FLUSH;
    assign wr = bus.sr_ie & bus.sup;
    assign wr_ctrl = wr && bus.sr_sel == 16'h0001;
    assign wr_fstat = wr && bus.sr_sel == 16'h0002;
    assign idx = bus.sr_sel[PAGE_BITS-1:0];
    assign sel_d = bus.sr_sel >= 16'h0100 && bus.sr_sel < 16'h0100 + 16'(ENTRIES);
    assign sel_p = bus.sr_sel >= 16'h0200 && bus.sr_sel < 16'h0200 + 16'(ENTRIES);
    assign unused = ^bus.sr_in;

    assign d_pg = bus.d_vaddr[VADDR_W-1 -: PAGE_BITS];
    assign p_pg = bus.p_vaddr[VADDR_W-1 -: PAGE_BITS];
    assign bus.d_paddr = dpg ? {d_ppn[d_pg], bus.d_vaddr[OFF_W-1:0]} : PADDR_W'(bus.d_vaddr);
    assign bus.p_paddr = ppg ? {p_ppn[p_pg], bus.p_vaddr[OFF_W-1:0]} : PADDR_W'(bus.p_vaddr);
    assign bus.d_fault = bus.d_req & dpg & ~busy & (~d_v[d_pg] | (bus.d_we & d_wp[d_pg]));
    assign bus.p_fault = bus.p_req & ppg & ~busy & ~p_v[p_pg];
    assign bus.busy = busy;
    assign bus.fault_irq = fv;

    assign bus.sr_out = bus.sr_sel == 16'h0001 ? {12'b0, ppg, busy, ppg_buf, dpg} :
                        bus.sr_sel == 16'h0002 ? {10'b0, sav, ovf, fp, fw, fv} :
                        bus.sr_sel == 16'h0003 ? 16'(faddr) :
                        sel_d ? {d_v[idx], d_wp[idx], 14'(d_ppn[idx])} :
                        sel_p ? {p_v[idx], p_wp[idx], 14'(p_ppn[idx])} : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FLUSH;
            cnt <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        if (busy) begin
            cnt_d = cnt + 1'b1;
            if (&cnt) state_d = IDLE;
        end else if (wr_ctrl && bus.sr_in[2]) begin
            state_d = FLUSH;
            cnt_d = '0;
        end
    end

    // Table contents are not reset; the flush that follows reset invalidates them.
    always_ff @(posedge clk) begin
        if (busy) begin
            d_v[cnt] <= 1'b0;
            d_wp[cnt] <= 1'b0;
            p_v[cnt] <= 1'b0;
            p_wp[cnt] <= 1'b0;
        end else if (rst) begin
            if (wr && sel_d) begin
                d_v[idx] <= bus.sr_in[15];
                d_wp[idx] <= bus.sr_in[14];
                d_ppn[idx] <= bus.sr_in[PPN_W-1:0];
            end
            if (wr && sel_p) begin
                p_v[idx] <= bus.sr_in[15];
                p_wp[idx] <= bus.sr_in[14];
                p_ppn[idx] <= bus.sr_in[PPN_W-1:0];
            end
        end
    end

    // irq_take is applied last so it overrides a same-cycle CTRL write and pc_commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            {dpg, ppg, ppg_buf} <= '0;
            {ovf, fp, fw, fv} <= '0;
            sav <= '0;
            faddr <= '0;
        end else begin
            if (bus.pc_commit) ppg <= ppg_buf;
            if (wr_ctrl) begin
                dpg <= bus.sr_in[0];
                ppg_buf <= bus.sr_in[1];
            end
            if (bus.irq_take) begin
                sav <= {ppg, dpg};
                {dpg, ppg, ppg_buf} <= '0;
            end
            if (wr_fstat) {ovf, fp, fw, fv} <= '0;
            // A same-cycle FSTAT clear lets the new fault be recorded as the first one.
            if (bus.d_fault | bus.p_fault) begin
                if (fv & ~wr_fstat) ovf <= 1'b1;
                else begin
                    fv <= 1'b1;
                    fw <= bus.d_fault & bus.d_we;
                    fp <= ~bus.d_fault;
                    faddr <= bus.d_fault ? bus.d_vaddr : bus.p_vaddr;
                    ovf <= bus.d_fault & bus.p_fault;
                end
            end
        end
    end
endmodule
